// File: rtl/lms_sample_sequencer.sv
// Drives one (x, d) pair at a time through the LMS core and returns (y, e) on a valid/ready stream.
// Also keeps a WAIT watchdog, delivered/dropped counters and a windowed mean |e| monitor.
module lms_sample_sequencer #(
  parameter int WIDTH    = 16,
  parameter int TIMEOUT  = 64,
  parameter int WIN_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_x,
  input  logic [WIDTH-1:0] s_d,
  output logic             core_start,
  output logic [WIDTH-1:0] core_x,
  output logic [WIDTH-1:0] core_d,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_y,
  input  logic [WIDTH-1:0] core_e,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_y,
  output logic [WIDTH-1:0] m_e,
  output logic [31:0]      sample_count,
  output logic [15:0]      drop_count,
  output logic             timeout_flag,
  output logic [WIDTH-1:0] err_avg,
  output logic             err_avg_valid
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int AW = WIDTH + WIN_LOG2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

  state_t              state, state_nxt;
  logic [TW-1:0]       timer;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_sum;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIDTH-1:0]    abs_e;
  logic                accept;
  logic                done_hit;
  logic                timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    core_start  = 1'b0;
    m_valid     = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        s_ready = !rst;
        if (s_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        // A done landing on the last watchdog cycle still counts as a result.
        if (core_done) begin
          done_hit  = 1'b1;
          state_nxt = OUTPUT;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      OUTPUT: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept  = s_valid && s_ready;
  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign abs_e   = core_e[WIDTH-1] ? (~core_e + WIDTH'(1)) : core_e;
  assign acc_sum = acc + AW'(abs_e);

  always_ff @(posedge clk) begin
    if (rst) begin
      core_x        <= '0;
      core_d        <= '0;
      m_y           <= '0;
      m_e           <= '0;
      timer         <= '0;
      sample_count  <= '0;
      drop_count    <= '0;
      timeout_flag  <= 1'b0;
      acc           <= '0;
      win_cnt       <= '0;
      err_avg       <= '0;
      err_avg_valid <= 1'b0;
    end else begin
      err_avg_valid <= 1'b0;
      if (accept) begin
        core_x <= s_x;
        core_d <= s_d;
      end
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;
      if (done_hit) begin
        m_y <= core_y;
        m_e <= core_e;
        if (win_cnt == '1) begin
          err_avg       <= acc_sum[AW-1:WIN_LOG2];
          err_avg_valid <= 1'b1;
          acc           <= '0;
          win_cnt       <= '0;
        end else begin
          acc     <= acc_sum;
          win_cnt <= win_cnt + 1'b1;
        end
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
      if (m_valid && m_ready) sample_count <= sample_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lms_sample_sequencer.sv
// Self-checking bench: stub LMS core with programmable latency, directed scenarios then random transactions.
module tb_lms_sample_sequencer;
  localparam int WIDTH    = 16;
  localparam int TIMEOUT  = 64;
  localparam int WIN_LOG2 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready;
  logic [15:0] s_x, s_d;
  logic        core_start;
  logic [15:0] core_x, core_d;
  logic        core_done;
  logic [15:0] core_y, core_e;
  logic        m_valid, m_ready;
  logic [15:0] m_y, m_e;
  logic [31:0] sample_count;
  logic [15:0] drop_count;
  logic        timeout_flag;
  logic [15:0] err_avg;
  logic        err_avg_valid;

  lms_sample_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .WIN_LOG2(WIN_LOG2)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_d(s_d),
    .core_start(core_start), .core_x(core_x), .core_d(core_d),
    .core_done(core_done), .core_y(core_y), .core_e(core_e),
    .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_e(m_e),
    .sample_count(sample_count), .drop_count(drop_count), .timeout_flag(timeout_flag),
    .err_avg(err_avg), .err_avg_valid(err_avg_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  // stub core: latency 0 means it never answers; use_d makes it behave like a zero-weight core (y=0, e=d)
  int          pend = 0;
  int          stub_lat = 1;
  logic [15:0] stub_y = '0, stub_e = '0;
  bit          use_d = 1'b0;
  // reference model state
  longint      exp_sample = 0;
  int          exp_drop = 0;
  bit          exp_tflag = 1'b0;
  int          win_sum = 0, win_n = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    core_done = 1'b0;
    if (rst) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done = 1'b1;
          core_y = use_d ? 16'h0 : stub_y;
          core_e = use_d ? core_d : stub_e;
        end
      end
      if (core_start) pend = stub_lat;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_ctrl", {core_start, m_valid, timeout_flag, err_avg_valid}, 0);
    chk("rst_core_xd", {core_x, core_d}, 0);
    chk("rst_m_ye", {m_y, m_e}, 0);
    chk("rst_counts", {sample_count, drop_count}, 0);
    chk("rst_err_avg", err_avg, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_s_ready", s_ready, 1);
    exp_sample = 0; exp_drop = 0; exp_tflag = 1'b0; win_sum = 0; win_n = 0;
  endtask

  task automatic run_txn(input logic [15:0] x, input logic [15:0] d, input int lat,
                         input logic [15:0] y, input logic [15:0] e, input bit ud, input int rdly);
    int          n;
    int          ev;
    logic [15:0] e_eff, y_eff;
    stub_lat = lat; stub_y = y; stub_e = e; use_d = ud;
    n = 0;
    while (!s_ready && n < 200) begin tick(); n++; end
    chk("s_ready_idle", s_ready, 1);
    s_valid = 1'b1; s_x = x; s_d = d;
    tick();
    s_valid = 1'b0; s_x = 16'($urandom); s_d = 16'($urandom);
    chk("issue_start", {core_start, s_ready}, 2'b10);
    chk("issue_xd", {core_x, core_d}, {x, d});
    for (n = 1; n <= TIMEOUT + 4; n++) begin
      tick();
      if (m_valid || s_ready) break;
      chk("wait_hold", {core_start, core_x, core_d}, {1'b0, x, d});
    end
    if (lat >= 1 && lat <= TIMEOUT) begin
      e_eff = ud ? d : e;
      y_eff = ud ? 16'h0 : y;
      chk("done_latency", n, lat + 1);
      chk("m_valid_set", {m_valid, s_ready}, 2'b10);
      chk("m_y", m_y, y_eff);
      chk("m_e", m_e, e_eff);
      chk("tflag_sticky", timeout_flag, exp_tflag);
      ev = int'($signed(e_eff));
      win_sum += (ev < 0) ? -ev : ev;
      win_n++;
      if (win_n == (1 << WIN_LOG2)) begin
        chk("avg_pulse", err_avg_valid, 1);
        chk("avg_value", err_avg, win_sum >> WIN_LOG2);
        win_sum = 0; win_n = 0;
      end else begin
        chk("avg_no_pulse", err_avg_valid, 0);
      end
      for (int i = 0; i < rdly; i++) begin
        m_ready = 1'b0;
        tick();
        chk("bp_hold", {m_valid, s_ready, m_y, m_e}, {2'b10, y_eff, e_eff});
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      exp_sample++;
      chk("post_hs", {m_valid, s_ready, err_avg_valid}, 3'b010);
      chk("sample_count", sample_count, exp_sample);
    end else begin
      chk("timeout_latency", n, TIMEOUT + 1);
      chk("timeout_no_valid", m_valid, 0);
      exp_drop++;
      exp_tflag = 1'b1;
      chk("drop_count", drop_count, exp_drop);
      chk("timeout_flag", timeout_flag, 1);
      chk("sample_unchanged", sample_count, exp_sample);
    end
  endtask

  task automatic stray_done();
    core_done = 1'b1;
    core_y = 16'($urandom); core_e = 16'($urandom);
    tick();
    chk("stray_ignored", {m_valid, s_ready, err_avg_valid}, 3'b010);
    chk("stray_counts", {sample_count, drop_count}, {32'(exp_sample), 16'(exp_drop)});
  endtask

  initial begin
    int r, lat;
    rst = 1'b1; s_valid = 1'b0; s_x = '0; s_d = '0; m_ready = 1'b0;
    core_done = 1'b0; core_y = '0; core_e = '0;
    do_reset();

    // basic transaction through a zero-weight core
    run_txn(16'h0100, 16'd100, 12, 16'h0, 16'h0, 1'b1, 0);
    // backpressure for 20 cycles
    run_txn(16'h1234, 16'h0F0F, 20, 16'h7777, 16'hFFF0, 1'b0, 20);
    // core never answers, then a normal sample
    run_txn(16'h0001, 16'h0002, 0, 16'h0, 16'h0, 1'b0, 0);
    run_txn(16'h0003, 16'h0004, 5, 16'h0055, 16'h0066, 1'b0, 1);
    // done exactly on the last watchdog cycle, then a stray done in IDLE
    run_txn(16'h00AA, 16'h00BB, TIMEOUT, 16'h1111, 16'h2222, 1'b0, 0);
    stray_done();

    // error window of four
    do_reset();
    run_txn(16'h0, 16'h0, 3, 16'h1, 16'd10, 1'b0, 0);
    run_txn(16'h0, 16'h0, 7, 16'h2, -16'sd20, 1'b0, 2);
    run_txn(16'h0, 16'h0, 4, 16'h3, 16'd30, 1'b0, 0);
    run_txn(16'h0, 16'h0, 9, 16'h4, 16'h8000, 1'b0, 1);
    chk("err_avg_8207", err_avg, 8207);

    // reset five cycles into WAIT
    run_txn(16'h0, 16'h0, 0, 16'h0, 16'h0, 1'b0, 0);
    stub_lat = 0;
    s_valid = 1'b1; s_x = 16'h5555; s_d = 16'h6666;
    tick();
    s_valid = 1'b0;
    chk("rw_issue", core_start, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("rw_in_wait", {s_ready, m_valid}, 2'b00);
    do_reset();
    run_txn(16'h0042, 16'h0043, 8, 16'h0044, 16'h0045, 1'b0, 0);

    // random traffic against the model
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      lat = 0;
      else if (r == 1) lat = int'($urandom_range(TIMEOUT - 1, TIMEOUT + 6));
      else             lat = int'($urandom_range(1, 20));
      if ($urandom_range(0, 4) == 0 && s_ready) stray_done();
      run_txn(16'($urandom), 16'($urandom), lat, 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
